// File: rtl/dfi_rddata_align.sv
// DFI read-data aligner: compacts valid PHY phases into full-width words and queues them in a FWFT FIFO.
// Optional macro DFI_RDDATA_INREG_EN registers dfi_rddata/dfi_rddata_valid ahead of the assembler.
module dfi_rddata_align #(
   parameter int C_DFI_FREQ_RATIO   = 4,
   parameter int C_DFI_DATA_WIDTH   = 64,
   parameter int C_DFI_DATAEN_WIDTH = 4,
   parameter int C_BEATS_PER_WORD   = 4,
   parameter int C_FIFO_DEPTH       = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [C_DFI_DATA_WIDTH*C_DFI_FREQ_RATIO-1:0]   dfi_rddata,
   input  logic [C_DFI_DATAEN_WIDTH*C_DFI_FREQ_RATIO-1:0] dfi_rddata_valid,
   input  logic                                          flush,
   output logic [C_BEATS_PER_WORD*C_DFI_DATA_WIDTH-1:0]   rd_data,
   output logic                                          rd_valid,
   input  logic                                          rd_ready,
   output logic [$clog2(C_FIFO_DEPTH+1)-1:0]             free_cnt,
   output logic [$clog2(C_BEATS_PER_WORD)-1:0]           partial_cnt,
   output logic                                          ovf,
   output logic                                          valid_err
);

   localparam int R  = C_DFI_FREQ_RATIO;
   localparam int W  = C_DFI_DATA_WIDTH;
   localparam int L  = C_DFI_DATAEN_WIDTH;
   localparam int B  = C_BEATS_PER_WORD;
   localparam int D  = C_FIFO_DEPTH;
   localparam int PW = $clog2(B);
   localparam int IW = $clog2(2 * B);
   localparam int AW = $clog2(D);
   localparam int FW = $clog2(D + 1);
   localparam logic [IW-1:0] B_L = IW'(B);

   logic [R*W-1:0] in_data;
   logic [R*L-1:0] in_lanes;

`ifdef DFI_RDDATA_INREG_EN
   always_ff @(posedge clk) begin
      if (rst || flush) in_lanes <= '0;
      else              in_lanes <= dfi_rddata_valid;
   end

   always_ff @(posedge clk) begin
      in_data <= dfi_rddata;
   end
`else
   assign in_data  = dfi_rddata;
   assign in_lanes = dfi_rddata_valid;
`endif

   // De-interleave the phase-minor bus layout into one beat per phase.
   logic [R-1:0][W-1:0] beat;
   logic [R-1:0]        ph_valid;
   logic                lane_err;

   always_comb begin
      beat     = '0;
      ph_valid = '0;
      lane_err = 1'b0;
      for (int unsigned p = 0; p < R; p++) begin
         for (int unsigned b = 0; b < W; b++) begin
            beat[p][b] = in_data[b*R + p];
         end
         ph_valid[p] = in_lanes[p];
         for (int unsigned l = 1; l < L; l++) begin
            if (in_lanes[l*R + p] != in_lanes[p]) lane_err = 1'b1;
         end
      end
   end

   // Assembler: held beats followed by this cycle's valid beats in a 2*B scratch row.
   logic [B-1:0][W-1:0]   hold;
   logic [PW-1:0]         cnt;
   logic [2*B-1:0][W-1:0] work;
   logic [IW-1:0]         pos;
   logic                  word_done;
   logic [B*W-1:0]        word;
   logic [B-1:0][W-1:0]   next_hold;
   logic [PW-1:0]         next_cnt;

   always_comb begin
      work        = '0;
      work[B-1:0] = hold;
      pos         = {1'b0, cnt};
      for (int unsigned p = 0; p < R; p++) begin
         if (ph_valid[p]) begin
            work[pos] = beat[p];
            pos       = pos + 1'b1;
         end
      end
      word_done = (pos >= B_L);
      word      = work[B-1:0];
      if (word_done) begin
         next_hold = work[2*B-1:B];
         next_cnt  = PW'(pos - B_L);
      end else begin
         next_hold = work[B-1:0];
         next_cnt  = PW'(pos);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt  <= '0;
         hold <= '0;
      end else begin
         cnt  <= next_cnt;
         hold <= next_hold;
      end
   end

   assign partial_cnt = cnt;

   // Output FIFO, first-word fall-through, extra pointer bit separates full from empty.
   logic [B*W-1:0] mem [D];
   logic [AW:0]    wp;
   logic [AW:0]    rp;
   logic [FW-1:0]  free_q;
   logic           full;
   logic           empty;
   logic           pop;
   logic           push;
   logic           drop;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

   assign rd_valid = !empty;
   assign rd_data  = empty ? '0 : mem[rp[AW-1:0]];

   assign pop  = rd_valid && rd_ready && !flush;
   assign push = word_done && !flush && (!full || pop);
   assign drop = word_done && !flush && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         free_q    <= FW'(D);
         ovf       <= 1'b0;
         valid_err <= 1'b0;
      end else begin
         if (lane_err) valid_err <= 1'b1;
         if (drop)     ovf       <= 1'b1;
         if (flush) begin
            wp     <= '0;
            rp     <= '0;
            free_q <= FW'(D);
         end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
               2'b10:   free_q <= free_q - 1'b1;
               2'b01:   free_q <= free_q + 1'b1;
               default: free_q <= free_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= word;
   end

   assign free_cnt = free_q;

endmodule
